// File: rtl/card_pkg.sv
// Shared definitions for the card shoe: deck geometry, card-value width,
// LFSR taps, FSM state encoding and the rank/value helper functions.
package card_pkg;

    localparam int DECK_SIZE = 52;
    localparam int RANKS     = 13;
    localparam int CARD_W    = 4;
    localparam int IDX_W     = 6;

    localparam logic [IDX_W-1:0] LAST_IDX  = 6'd51;
    localparam logic [15:0]      LFSR_TAPS = 16'hB400;

    // FSM encoding kept as plain constants for compatibility with older tools
    localparam logic [1:0] ST_INIT    = 2'd0;
    localparam logic [1:0] ST_SHUFFLE = 2'd1;
    localparam logic [1:0] ST_READY   = 2'd2;
    localparam logic [1:0] ST_DEAL    = 2'd3;

    // Blackjack value of a rank: face cards (J, Q, K) and ten all count 10
    function automatic logic [CARD_W-1:0] rank_to_value(input logic [CARD_W-1:0] rank);
        logic [CARD_W-1:0] val;
        if (rank >= 4'd10) begin
            val = 4'd10;
        end else begin
            val = rank;
        end
        return val;
    endfunction

    // Rank stored at a deck position after a fresh fill: (idx mod 13) + 1
    function automatic logic [CARD_W-1:0] init_rank(input logic [IDX_W-1:0] idx);
        logic [IDX_W-1:0] m;
        m = idx % 6'(RANKS);
        return m[CARD_W-1:0] + 4'd1;
    endfunction

endpackage

// File: rtl/card_shoe_lfsr16.sv
// Free-running 16-bit Galois LFSR (shift right). A zero seed would lock
// the register at zero forever, so it is replaced by 1.
module lfsr16
    import card_pkg::*;
#(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [15:0] state
);

    localparam logic [15:0] SEED_EFF = (SEED == 16'h0000) ? 16'h0001 : SEED;

    logic [15:0] state_r;

    // Advance one step every cycle; feedback XORs the taps when bit 0 shifts out
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= SEED_EFF;
        end else begin
            state_r <= (state_r >> 1) ^ (state_r[0] ? LFSR_TAPS : 16'h0000);
        end
    end

    assign state = state_r;

endmodule

// File: rtl/card_shoe.sv
// Card shoe: fills a 52-card deck, shuffles it in place with a Fisher-Yates
// pass (rejection-sampled LFSR indices), then deals one card per request.
// The deck is reshuffled automatically once it runs dry.
module card_shoe
    import card_pkg::*;
#(
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              shuffle_req,
    input  logic              card_req,
    output logic [CARD_W-1:0] card_value,
    output logic              card_valid,
    output logic              ready,
    output logic              busy,
    output logic [IDX_W-1:0]  cards_left
);

    logic [1:0]        state_r;
    logic [1:0]        state_nxt_s;
    logic [IDX_W-1:0]  idx_r;
    logic [IDX_W-1:0]  ptr_r;
    logic [IDX_W-1:0]  left_r;
    logic [CARD_W-1:0] deck_r [DECK_SIZE];
    logic [CARD_W-1:0] card_value_r;
    logic              card_valid_r;
    logic              ready_r;
    logic              busy_r;

    logic [15:0]       lfsr_s;
    logic [IDX_W-1:0]  cand_j_s;
    logic [IDX_W-1:0]  swap_j_s;
    logic              accept_s;
    logic              unused_lfsr_s;

    lfsr16 #(
        .SEED (LFSR_SEED)
    ) u_lfsr (
        .clk   (clk),
        .rst_n (rst_n),
        .state (lfsr_s)
    );

    // Only the low six LFSR bits form the candidate index
    assign unused_lfsr_s = ^lfsr_s[15:IDX_W];

    // Candidate swap index; a rejected candidate is steered back to i so the
    // deck read never leaves the 0..51 range
    always_comb begin
        cand_j_s = lfsr_s[IDX_W-1:0];
        accept_s = (state_r == ST_SHUFFLE) && (cand_j_s <= idx_r);
        if (accept_s) begin
            swap_j_s = cand_j_s;
        end else begin
            swap_j_s = idx_r;
        end
    end

    // Next-state decode; shuffle_req has priority over card_req in READY
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_INIT: begin
                if (idx_r == LAST_IDX) begin
                    state_nxt_s = ST_SHUFFLE;
                end else begin
                    state_nxt_s = ST_INIT;
                end
            end
            ST_SHUFFLE: begin
                if (accept_s && (idx_r == 6'd1)) begin
                    state_nxt_s = ST_READY;
                end else begin
                    state_nxt_s = ST_SHUFFLE;
                end
            end
            ST_READY: begin
                if (shuffle_req) begin
                    state_nxt_s = ST_SHUFFLE;
                end else if (card_req) begin
                    state_nxt_s = ST_DEAL;
                end else begin
                    state_nxt_s = ST_READY;
                end
            end
            ST_DEAL: begin
                if (left_r == 6'd0) begin
                    state_nxt_s = ST_SHUFFLE;
                end else begin
                    state_nxt_s = ST_READY;
                end
            end
            default: begin
                state_nxt_s = ST_INIT;
            end
        endcase
    end

    // Control registers: state, fill/shuffle index, deal pointer, outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= ST_INIT;
            idx_r        <= 6'd0;
            ptr_r        <= 6'd0;
            left_r       <= 6'd0;
            card_value_r <= 4'd0;
            card_valid_r <= 1'b0;
            ready_r      <= 1'b0;
            busy_r       <= 1'b1;
        end else begin
            state_r      <= state_nxt_s;
            ready_r      <= (state_nxt_s == ST_READY);
            busy_r       <= (state_nxt_s == ST_INIT) || (state_nxt_s == ST_SHUFFLE);
            card_valid_r <= 1'b0;
            case (state_r)
                ST_INIT: begin
                    // Index parks at 51, which is exactly where the shuffle starts
                    if (idx_r != LAST_IDX) begin
                        idx_r <= idx_r + 6'd1;
                    end
                end
                ST_SHUFFLE: begin
                    if (accept_s) begin
                        if (idx_r == 6'd1) begin
                            ptr_r  <= 6'd0;
                            left_r <= 6'(DECK_SIZE);
                        end else begin
                            idx_r <= idx_r - 6'd1;
                        end
                    end
                end
                ST_READY: begin
                    if (shuffle_req) begin
                        idx_r  <= LAST_IDX;
                        left_r <= 6'd0;
                    end else if (card_req) begin
                        card_value_r <= rank_to_value(deck_r[ptr_r]);
                        card_valid_r <= 1'b1;
                        ptr_r        <= ptr_r + 6'd1;
                        left_r       <= left_r - 6'd1;
                    end
                end
                ST_DEAL: begin
                    if (left_r == 6'd0) begin
                        idx_r <= LAST_IDX;
                    end
                end
                default: begin
                    idx_r <= 6'd0;
                end
            endcase
        end
    end

    // Deck storage: sequential fill in INIT, two-port swap in SHUFFLE
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < DECK_SIZE; k++) begin
                deck_r[k] <= 4'd0;
            end
        end else begin
            case (state_r)
                ST_INIT: begin
                    deck_r[idx_r] <= init_rank(idx_r);
                end
                ST_SHUFFLE: begin
                    if (accept_s) begin
                        deck_r[idx_r]    <= deck_r[swap_j_s];
                        deck_r[swap_j_s] <= deck_r[idx_r];
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign card_value = card_value_r;
    assign card_valid = card_valid_r;
    assign ready      = ready_r;
    assign busy       = busy_r;
    assign cards_left = left_r;

endmodule

// File: tb/tb_card_shoe.sv
// Bench for card_shoe: a reference shoe model predicts every dealt value,
// a scoreboard queue holds the predictions and a monitor pops them on each
// card_valid pulse. A second instance with seed 0 is checked against the
// model run with seed 1.
module tb_card_shoe;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       shuffle_req;
    logic       card_req;
    logic       sel;

    logic [3:0] cv_a, cv_b, o_cv;
    logic       vld_a, vld_b, o_vld;
    logic       rdy_a, rdy_b, o_rdy;
    logic       busy_a, busy_b, o_busy;
    logic [5:0] left_a, left_b, o_left;

    card_shoe dut_a (
        .clk(clk), .rst_n(rst_n), .shuffle_req(shuffle_req), .card_req(card_req),
        .card_value(cv_a), .card_valid(vld_a), .ready(rdy_a), .busy(busy_a),
        .cards_left(left_a)
    );

    card_shoe #(.LFSR_SEED(16'h0000)) dut_b (
        .clk(clk), .rst_n(rst_n), .shuffle_req(shuffle_req), .card_req(card_req),
        .card_value(cv_b), .card_valid(vld_b), .ready(rdy_b), .busy(busy_b),
        .cards_left(left_b)
    );

    always #5 clk = ~clk;

    // Observe the instance currently under test
    always_comb begin
        o_cv   = sel ? cv_b   : cv_a;
        o_vld  = sel ? vld_b  : vld_a;
        o_rdy  = sel ? rdy_b  : rdy_a;
        o_busy = sel ? busy_b : busy_a;
        o_left = sel ? left_b : left_a;
    end

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        int val;
        int left;
    } exp_t;

    exp_t        sb_q[$];
    exp_t        mon_e;
    int          hist[16];
    logic [3:0]  m_deck [52];
    int          m_ptr;
    int          m_left;
    logic [15:0] m_seed = 16'hACE1;
    logic [15:0] lfsr_m;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        return (s >> 1) ^ (s[0] ? 16'hB400 : 16'h0000);
    endfunction

    function automatic int exp_value(input logic [3:0] r);
        return (r >= 4'd10) ? 10 : int'(r);
    endfunction

    // Reference LFSR, free-running like the one inside the shoe
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) lfsr_m <= m_seed;
        else        lfsr_m <= lfsr_step(lfsr_m);
    end

    // Monitor: every card_valid pulse consumes one predicted card
    always @(negedge clk) begin
        if (rst_n && o_vld) begin
            if (sb_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_valid: got value %0d, expected no card (t=%0t)", o_cv, $time);
            end else begin
                mon_e = sb_q.pop_front();
                check("deal_value", int'(o_cv), mon_e.val);
                check("deal_left", int'(o_left), mon_e.left);
            end
            hist[o_cv]++;
        end
    end

    // Fisher-Yates with rejection, starting from the LFSR value the shoe
    // will use on its first SHUFFLE edge; returns the cycle count
    task automatic model_shuffle(output int cyc);
        logic [15:0] l;
        logic [3:0]  t;
        int i;
        int j;
        l   = lfsr_m;
        i   = 51;
        cyc = 0;
        while (cyc < 20000) begin
            j = int'(l[5:0]);
            cyc++;
            if (j <= i) begin
                t         = m_deck[i];
                m_deck[i] = m_deck[j];
                m_deck[j] = t;
                if (i == 1) break;
                i--;
            end
            l = lfsr_step(l);
        end
    endtask

    task automatic check_reset_outs(input string tag);
        check({tag, "_value"}, int'(o_cv), 0);
        check({tag, "_valid"}, int'(o_vld), 0);
        check({tag, "_ready"}, int'(o_rdy), 0);
        check({tag, "_busy"}, int'(o_busy), 1);
        check({tag, "_left"}, int'(o_left), 0);
    endtask

    task automatic check_hist();
        for (int v = 1; v <= 9; v++) check("hist_low", hist[v], 4);
        check("hist_ten", hist[10], 16);
    endtask

    // Called on the first negedge in SHUFFLE; follows the predicted length
    task automatic wait_shuffle(input bit poke);
        int c;
        for (int v = 0; v < 16; v++) hist[v] = 0;
        model_shuffle(c);
        for (int k = 0; k < c; k++) begin
            check("shuf_busy", int'(o_busy), 1);
            check("shuf_ready", int'(o_rdy), 0);
            if (poke && k == 5) begin
                card_req    = 1'b1;
                shuffle_req = 1'b1;
            end
            @(negedge clk);
            card_req    = 1'b0;
            shuffle_req = 1'b0;
            if (poke && k == 5) begin
                check("shuf_drop_valid", int'(o_vld), 0);
                check("shuf_drop_left", int'(o_left), 0);
            end
        end
        check("shuf_done_ready", int'(o_rdy), 1);
        check("shuf_done_busy", int'(o_busy), 0);
        check("shuf_done_left", int'(o_left), 52);
        m_ptr  = 0;
        m_left = 52;
    endtask

    task automatic do_reset(input bit s, input bit poke);
        sel         = s;
        m_seed      = s ? 16'h0001 : 16'hACE1;
        card_req    = 1'b0;
        shuffle_req = 1'b0;
        rst_n       = 1'b0;
        sb_q.delete();
        repeat (3) @(negedge clk);
        check_reset_outs("rst");
        rst_n = 1'b1;
        for (int i = 0; i < 52; i++) m_deck[i] = 4'((i % 13) + 1);
        for (int k = 0; k < 52; k++) begin
            check("init_busy", int'(o_busy), 1);
            check("init_ready", int'(o_rdy), 0);
            if (poke && k == 10) begin
                card_req    = 1'b1;
                shuffle_req = 1'b1;
            end
            @(negedge clk);
            card_req    = 1'b0;
            shuffle_req = 1'b0;
            if (poke && k == 10) begin
                check("init_drop_valid", int'(o_vld), 0);
                check("init_drop_left", int'(o_left), 0);
            end
        end
        wait_shuffle(poke);
    endtask

    // One deal from READY; optionally holds card_req through the DEAL cycle
    task automatic deal_one(input bit poke_deal);
        exp_t e;
        check("pre_deal_ready", int'(o_rdy), 1);
        card_req = 1'b1;
        e.val    = exp_value(m_deck[m_ptr]);
        e.left   = m_left - 1;
        sb_q.push_back(e);
        m_ptr++;
        m_left--;
        @(negedge clk);
        check("deal_ready_low", int'(o_rdy), 0);
        check("deal_busy_low", int'(o_busy), 0);
        if (!poke_deal) card_req = 1'b0;
        @(negedge clk);
        card_req = 1'b0;
        if (poke_deal) begin
            check("deal_drop_valid", int'(o_vld), 0);
            check("deal_drop_left", int'(o_left), m_left);
        end
    endtask

    task automatic deal_n(input int n);
        for (int d = 0; d < n; d++) deal_one(d == 3);
        if (m_left == 0) begin
            check("auto_reshuffle_busy", int'(o_busy), 1);
            check("auto_reshuffle_ready", int'(o_rdy), 0);
            check_hist();
            wait_shuffle(1'b0);
        end
    endtask

    initial begin
        exp_t e;
        sel         = 1'b0;
        rst_n       = 1'b0;
        card_req    = 1'b0;
        shuffle_req = 1'b0;
        for (int v = 0; v < 16; v++) hist[v] = 0;

        // Clean reset with requests poked during INIT and SHUFFLE, full deck
        do_reset(1'b0, 1'b1);
        deal_n(52);

        // Ten deals, then both requests together: shuffle wins
        deal_n(10);
        check("both_pre_left", int'(o_left), 42);
        check("both_pre_ready", int'(o_rdy), 1);
        card_req    = 1'b1;
        shuffle_req = 1'b1;
        @(negedge clk);
        card_req    = 1'b0;
        shuffle_req = 1'b0;
        check("both_no_valid", int'(o_vld), 0);
        check("both_busy", int'(o_busy), 1);
        check("both_left", int'(o_left), 0);
        wait_shuffle(1'b0);
        deal_n(52);

        // Reset dropped mid-SHUFFLE
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (70) @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check_reset_outs("mid_shuf_rst");

        // Reset dropped in a DEAL cycle after a few deals
        do_reset(1'b0, 1'b0);
        deal_n(5);
        check("mid_deal_pre_ready", int'(o_rdy), 1);
        card_req = 1'b1;
        e.val    = exp_value(m_deck[m_ptr]);
        e.left   = m_left - 1;
        sb_q.push_back(e);
        @(negedge clk);
        card_req = 1'b0;
        #2 rst_n = 1'b0;
        #1 check_reset_outs("mid_deal_rst");

        // Clean sequence repeats after reset
        do_reset(1'b0, 1'b0);
        deal_n(52);

        // Seed 0 instance must behave exactly like seed 1
        do_reset(1'b1, 1'b0);
        deal_n(52);

        repeat (2) @(negedge clk);
        check("scoreboard_empty", sb_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
